// File: rtl/paralelo_serie.sv
// Transmit-side parallel-to-serial stage: serialises bytes MSB-first on clk_8f,
// preceded by a comma preamble after every enable so the receiver can lock.
module paralelo_serie #(
  parameter logic [7:0] COMMA       = 8'hBC,
  parameter int         SYNC_COMMAS = 4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       tx_enable,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       data_out,
  output logic       byte_req,
  output logic       active
);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    ACTIVE
  } state_t;

  localparam logic [2:0] SYNC_LAST = 3'(SYNC_COMMAS);

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q;
  logic [2:0] comma_cnt_q, comma_cnt_d;
  logic [7:0] shift_q;
  logic [7:0] load_byte;
  logic       boundary;

  assign boundary = (bit_cnt_q == 3'd7);

  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    load_byte   = 8'h00;
    if (boundary) begin
      if (!tx_enable) begin
        // Disabling from any state sends a zero byte and forgets the preamble.
        state_d     = IDLE;
        comma_cnt_d = 3'd0;
        load_byte   = 8'h00;
      end else begin
        case (state_q)
          IDLE: begin
            load_byte   = COMMA;
            comma_cnt_d = 3'd1;
            state_d     = (SYNC_LAST == 3'd1) ? ACTIVE : SYNC;
          end
          SYNC: begin
            load_byte   = COMMA;
            comma_cnt_d = (comma_cnt_q == 3'd7) ? 3'd7 : comma_cnt_q + 3'd1;
            if (comma_cnt_d == SYNC_LAST) begin
              state_d = ACTIVE;
            end
          end
          ACTIVE: begin
            load_byte = valid_in ? data_in : COMMA;
          end
          default: begin
            state_d     = IDLE;
            comma_cnt_d = 3'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      comma_cnt_q <= 3'd0;
      shift_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_q + 3'd1;
      comma_cnt_q <= comma_cnt_d;
      if (boundary) begin
        shift_q <= load_byte;
      end else begin
        shift_q <= {shift_q[6:0], 1'b0};
      end
    end
  end

  assign data_out = shift_q[7];
  assign active   = (state_q == ACTIVE);
  assign byte_req = active & boundary & tx_enable;

endmodule

// File: doc/paralelo_serie.md
# paralelo_serie

Transmit-side parallel-to-serial stage of the PHY. It sits directly upstream of the serial-to-parallel receiver and drives its `data_in` line. The block serialises bytes MSB-first at the bit clock `clk_8f` and brackets link start-up with a run of 0xBC commas so the receiver can lock and raise `active`. When no valid byte is offered, it fills idle byte slots with 0xBC.

## Interface
- `COMMA`, 8'hBC: idle/synchronisation symbol.
- `SYNC_COMMAS`, 4: commas sent after enable before the first data slot; legal range 1..7.

- `clk_8f`  input  1  bit clock, the only clock; all state on its rising edge.
- `reset`  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- `tx_enable`  input  1  link enable; sampled only at byte boundaries.
- `data_in`  input  8  parallel byte; sampled only when `byte_req`=1.
- `valid_in`  input  1  `data_in` is a real byte; sampled only when `byte_req`=1.
- `data_out`  output  1  serial line, registered, MSB first.
- `byte_req`  output  1  byte-slot strobe: the upstream byte is consumed in this cycle.
- `active`  output  1  high while the FSM is in ACTIVE.

## Operation
Registers:
- `bit_cnt`: 3-bit, free-running 0..7, wraps 7→0.
- `shift`: 8-bit shift register; `data_out` = `shift[7]`.
- `comma_cnt`: 3-bit, saturating.
- `state`: IDLE / SYNC / ACTIVE.

Byte boundary:
- A boundary is any cycle with `bit_cnt`=7. At its closing edge `shift` loads the next byte.
- On every non-boundary edge `shift` shifts left by one, filling with 0.

FSM, evaluated only at boundaries:
- IDLE, `tx_enable`=0: load 0x00, `comma_cnt`←0, stay IDLE.
- IDLE, `tx_enable`=1: load `COMMA`, `comma_cnt`←1. Go to ACTIVE if `SYNC_COMMAS`=1, otherwise SYNC.
- SYNC, `tx_enable`=1: load `COMMA`, `comma_cnt`+1. When the new count equals `SYNC_COMMAS`, go to ACTIVE; otherwise stay SYNC.
- ACTIVE, `tx_enable`=1: load `data_in` if `valid_in`=1, otherwise load `COMMA`. Stay ACTIVE.
- SYNC or ACTIVE, `tx_enable`=0: load 0x00, `comma_cnt`←0, go to IDLE. No byte is consumed.

Outputs:
- `byte_req` = (`state`==ACTIVE) & (`bit_cnt`==7) & `tx_enable`. Combinational from registers plus `tx_enable`.
- `active` = (`state`==ACTIVE).

Data handling:
- A `data_in` equal to `COMMA` with `valid_in`=1 is transmitted unchanged. Avoiding this is the upstream's responsibility.
- `comma_cnt` saturates and never wraps.
- Upstream must hold `data_in`/`valid_in` stable through the `byte_req` cycle only. No backpressure exists: every `byte_req` consumes a slot.

## Timing
- Reset values: `bit_cnt`=0, `shift`=0x00, `comma_cnt`=0, `state`=IDLE, `data_out`=0, `byte_req`=0, `active`=0.
- Reset asserted mid-byte: `data_out` goes to 0 asynchronously. The partial byte is discarded, and the sequence restarts from cycle 0 after release.
- Cycle numbering: cycle 0 is the first rising edge after reset release. With `tx_enable`=1 throughout and default parameters:
  - Cycles 0–7: `data_out`=0.
  - Cycles 8–39: four commas, each 1,0,1,1,1,1,0,0.
  - Cycle 32: `active` rises.
  - Cycle 39: first `byte_req`.
  - Cycles 40–47: the first data slot on `data_out`.
- Byte latency: a byte sampled at the edge closing cycle N appears as its MSB in cycle N+1. It occupies cycles N+1..N+8.
- `byte_req` period is exactly 8 cycles while ACTIVE and enabled.
- Dropping `tx_enable` at a boundary ends ACTIVE at that edge; the following 8 bits are 0.
- Re-enabling restarts the full `SYNC_COMMAS` comma preamble.

## Test plan
- **Reset release, default parameters**, `tx_enable`=1, `valid_in`=0: `data_out` = 8 zeros, then continuous 0xBC patterns. `active`=1 from cycle 32. `byte_req` pulses at cycles 39, 47, 55, ….
- **Data slot:** `valid_in`=1, `data_in`=0xA5 at cycle 39 → cycles 40–47 carry 1,0,1,0,0,1,0,1. Cycle 47 with `valid_in`=0 → the next slot carries 0xBC.
- **Disable/re-enable:** `tx_enable`=0 at boundary cycle 47:
  - `byte_req`=0 there, `active` falls at cycle 48, cycles 48–55 are 0.
  - `tx_enable`=1 at cycle 55 → commas in cycles 56–87, `active` rises at cycle 80, `byte_req` at cycle 87.
- **Asynchronous reset at cycle 43**, mid-data byte: `data_out`, `active`, `byte_req` = 0 immediately. After release, the cycle-0 sequence repeats exactly.
- **`SYNC_COMMAS`=1:** `active` rises at cycle 8, first `byte_req` at cycle 15. Feeding 0xBC with `valid_in`=1 transmits 0xBC.
- **Loopback into the receiver:** serialised stream 0xBC ×4 then 0x11, 0x22 → receiver `active`=1 and recovered bytes 0x11, 0x22 in order.
